// File: rtl/dual_dispatch_rs.sv
// Two-wide reservation station: collapsing age-ordered queue with CDB wakeup, oldest-ready
// select into a valid/ready issue register, and branch flush/commit of speculative entries.
module dual_dispatch_rs #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dispVal1,
  input  logic              dispVal2,
  input  logic [TAG_W-1:0]  rstag1in,
  input  logic [TAG_W-1:0]  rstag2in,
  input  logic [TAG_W-1:0]  rstag3in,
  input  logic [TAG_W-1:0]  rstag4in,
  input  logic [DATA_W-1:0] dataRs1in,
  input  logic [DATA_W-1:0] dataRt1in,
  input  logic [DATA_W-1:0] dataRs2in,
  input  logic [DATA_W-1:0] dataRt2in,
  input  logic [DATA_W-1:0] imm1in,
  input  logic [DATA_W-1:0] imm2in,
  input  logic [5:0]        ctrl1in,
  input  logic [5:0]        ctrl2in,
  input  logic [2:0]        func1in,
  input  logic [2:0]        func2in,
  input  logic [TAG_W-1:0]  robDest1in,
  input  logic [TAG_W-1:0]  robDest2in,
  input  logic              spec1in,
  input  logic              spec2in,
  input  logic              cdbVal1,
  input  logic              cdbVal2,
  input  logic [TAG_W-1:0]  cdbTag1,
  input  logic [TAG_W-1:0]  cdbTag2,
  input  logic [DATA_W-1:0] cdbData1,
  input  logic [DATA_W-1:0] cdbData2,
  input  logic              flush,
  input  logic              commitSpec,
  output logic              rsStall,
  output logic              issueValid,
  input  logic              issueReady,
  output logic [DATA_W-1:0] issueA,
  output logic [DATA_W-1:0] issueB,
  output logic [DATA_W-1:0] issueImm,
  output logic [5:0]        issueCtrl,
  output logic [2:0]        issueFunc,
  output logic [TAG_W-1:0]  issueRobDest,
  output logic              issueSpec
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag_a;
    logic [TAG_W-1:0]  tag_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] imm;
    logic [5:0]        ctrl;
    logic [2:0]        func;
    logic [TAG_W-1:0]  rob_dest;
    logic              spec;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          n1, n2, tmp;
  logic [CntW-1:0] count_q, count_d, wr;
  logic [DEPTH-1:0] valid, ready, keep;
  logic            load, sel_found, accept;
  logic [IdxW-1:0] sel_idx;

  logic              iss_valid_q, iss_valid_d, iss_spec_q, iss_spec_d;
  logic [DATA_W-1:0] iss_a_q, iss_a_d, iss_b_q, iss_b_d, iss_imm_q, iss_imm_d;
  logic [5:0]        iss_ctrl_q, iss_ctrl_d;
  logic [2:0]        iss_func_q, iss_func_d;
  logic [TAG_W-1:0]  iss_rob_q, iss_rob_d;

  // Capture broadcast results for pending operands; port 1 wins on a shared tag.
  function automatic entry_t wake(entry_t e);
    entry_t r;
    r = e;
    if (r.tag_a != '0 && cdbVal1 && cdbTag1 == r.tag_a) begin
      r.data_a = cdbData1;
      r.tag_a  = '0;
    end else if (r.tag_a != '0 && cdbVal2 && cdbTag2 == r.tag_a) begin
      r.data_a = cdbData2;
      r.tag_a  = '0;
    end
    if (r.tag_b != '0 && cdbVal1 && cdbTag1 == r.tag_b) begin
      r.data_b = cdbData1;
      r.tag_b  = '0;
    end else if (r.tag_b != '0 && cdbVal2 && cdbTag2 == r.tag_b) begin
      r.data_b = cdbData2;
      r.tag_b  = '0;
    end
    return r;
  endfunction

  assign n1 = wake(entry_t'{tag_a: rstag1in, tag_b: rstag2in, data_a: dataRs1in,
                            data_b: dataRt1in, imm: imm1in, ctrl: ctrl1in, func: func1in,
                            rob_dest: robDest1in, spec: spec1in & ~commitSpec});
  assign n2 = wake(entry_t'{tag_a: rstag3in, tag_b: rstag4in, data_a: dataRs2in,
                            data_b: dataRt2in, imm: imm2in, ctrl: ctrl2in, func: func2in,
                            rob_dest: robDest2in, spec: spec2in & ~commitSpec});

  assign rsStall = count_q > CntW'(DEPTH - 2);
  assign load    = !flush && (!iss_valid_q || issueReady);
  assign accept  = !flush && !rsStall;

  // Oldest-ready select uses registered tags, so a same-cycle wakeup cannot issue.
  always_comb begin
    valid     = '0;
    ready     = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = count_q > CntW'(i);
      ready[i] = valid[i] && ent_q[i].tag_a == '0 && ent_q[i].tag_b == '0;
      if (ready[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
    end
  end

  // Compact survivors toward entry 0, then append slot 1 and slot 2 at the new tail.
  always_comb begin
    ent_d = ent_q;
    keep  = '0;
    tmp   = '0;
    wr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = valid[i] && !(load && sel_found && sel_idx == IdxW'(i)) &&
                !(flush && ent_q[i].spec);
      if (keep[i]) begin
        tmp      = wake(ent_q[i]);
        tmp.spec = tmp.spec & ~commitSpec;
        ent_d[wr[IdxW-1:0]] = tmp;
        wr = wr + CntW'(1);
      end
    end
    if (accept && dispVal1) begin
      ent_d[wr[IdxW-1:0]] = n1;
      wr = wr + CntW'(1);
    end
    if (accept && dispVal2) begin
      ent_d[wr[IdxW-1:0]] = n2;
      wr = wr + CntW'(1);
    end
    count_d = wr;
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_imm_d   = iss_imm_q;
    iss_ctrl_d  = iss_ctrl_q;
    iss_func_d  = iss_func_q;
    iss_rob_d   = iss_rob_q;
    iss_spec_d  = iss_spec_q;
    if (flush) begin
      if (iss_spec_q) iss_valid_d = 1'b0;
    end else begin
      if (commitSpec) iss_spec_d = 1'b0;
      if (load) begin
        iss_valid_d = sel_found;
        if (sel_found) begin
          iss_a_d    = ent_q[sel_idx].data_a;
          iss_b_d    = ent_q[sel_idx].data_b;
          iss_imm_d  = ent_q[sel_idx].imm;
          iss_ctrl_d = ent_q[sel_idx].ctrl;
          iss_func_d = ent_q[sel_idx].func;
          iss_rob_d  = ent_q[sel_idx].rob_dest;
          iss_spec_d = ent_q[sel_idx].spec & ~commitSpec;
        end
      end
    end
  end

  // Entry payloads need no reset: count alone defines which entries are live.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_imm_q   <= '0;
      iss_ctrl_q  <= '0;
      iss_func_q  <= '0;
      iss_rob_q   <= '0;
      iss_spec_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_imm_q   <= iss_imm_d;
      iss_ctrl_q  <= iss_ctrl_d;
      iss_func_q  <= iss_func_d;
      iss_rob_q   <= iss_rob_d;
      iss_spec_q  <= iss_spec_d;
    end
  end

  assign issueValid   = iss_valid_q;
  assign issueA       = iss_a_q;
  assign issueB       = iss_b_q;
  assign issueImm     = iss_imm_q;
  assign issueCtrl    = iss_ctrl_q;
  assign issueFunc    = iss_func_q;
  assign issueRobDest = iss_rob_q;
  assign issueSpec    = iss_spec_q;

endmodule
